// File: rtl/dp_types_pkg.sv
// Shared datapath types for the fetch stage: word, IF/ID latch layout and fetch FSM states.
package dp_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t imemload;
        word_t pc;
        word_t pc4;
    } IF_ID_t;

    typedef enum logic [1:0] {
        FETCH,
        DISCARD,
        HALTED
    } fetch_state_t;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter and pending redirect target; load decisions come from fetch_stage.
module pc_reg
    import dp_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  pc_en,
    input  word_t pc_next,
    input  logic  pend_en,
    input  word_t pend_next,
    output word_t pc,
    output word_t pending_pc
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc         <= PC_INIT;
            pending_pc <= '0;
        end else begin
            if (pc_en)
                pc <= pc_next;
            if (pend_en)
                pending_pc <= pend_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling across in-flight requests,
// stall/flush control of the IF/ID latch, and halt.
module fetch_stage
    import dp_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   ihit,
    input  word_t  imemload,
    output logic   imemREN,
    output word_t  imemaddr,
    input  logic   stall,
    input  logic   flush,
    input  logic   redirect,
    input  word_t  redirect_pc,
    input  logic   halt_in,
    output IF_ID_t ifid,
    output logic   ifid_valid
);

    fetch_state_t state;
    word_t        pc;
    word_t        pending_pc;
    word_t        pc_plus4;
    word_t        target;
    word_t        pc_next;
    word_t        pend_next;
    logic         pc_en;
    logic         pend_en;
    logic         hit;

    // A response only counts while a request is actually outstanding.
    assign hit      = ihit & imemREN;
    assign pc_plus4 = pc + 32'd4;
    assign target   = align_word(redirect_pc);
    assign imemaddr = pc;

    pc_reg #(
        .PC_INIT(PC_INIT)
    ) u_pc_reg (
        .CLK        (CLK),
        .nRST       (nRST),
        .pc_en      (pc_en),
        .pc_next    (pc_next),
        .pend_en    (pend_en),
        .pend_next  (pend_next),
        .pc         (pc),
        .pending_pc (pending_pc)
    );

    always_comb begin
        pc_en     = 1'b0;
        pc_next   = pc_plus4;
        pend_en   = 1'b0;
        pend_next = target;
        if (!halt_in) begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (hit) begin
                            pc_en   = 1'b1;
                            pc_next = target;
                        end else begin
                            pend_en = 1'b1;
                        end
                    end else if (hit && !stall && !flush) begin
                        pc_en = 1'b1;
                    end
                end
                DISCARD: begin
                    pend_en = redirect;
                    if (hit) begin
                        // A redirect arriving with the response is the newest target.
                        pc_en   = 1'b1;
                        pc_next = redirect ? target : pending_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            ifid       <= '0;
            ifid_valid <= 1'b0;
            imemREN    <= 1'b0;
        end else if (halt_in) begin
            state      <= HALTED;
            ifid       <= '0;
            ifid_valid <= 1'b0;
            imemREN    <= 1'b0;
        end else begin
            case (state)
                HALTED: imemREN <= 1'b0;
                default: begin
                    imemREN <= 1'b1;
                    if (state == FETCH && redirect && !hit)
                        state <= DISCARD;
                    else if (state == DISCARD && hit)
                        state <= FETCH;

                    // Words returned in a redirect or discard cycle become bubbles.
                    if (flush) begin
                        ifid       <= '0;
                        ifid_valid <= 1'b0;
                    end else if (!stall && hit) begin
                        if (state == FETCH && !redirect) begin
                            ifid       <= {imemload, pc, pc_plus4};
                            ifid_valid <= 1'b1;
                        end else begin
                            ifid       <= '0;
                            ifid_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall/flush, redirect during
// an outstanding request, PC wrap and halt/reset recovery.
module tb_fetch_stage;
    import dp_types_pkg::*;

    localparam word_t LOAD_KEY = 32'hA5A5_0000;

    logic   CLK;
    logic   nRST;
    logic   ihit;
    word_t  imemload;
    logic   stall;
    logic   flush;
    logic   redirect;
    word_t  redirect_pc;
    logic   halt_in;

    logic   imemREN_a, imemREN_b;
    word_t  imemaddr_a, imemaddr_b;
    IF_ID_t ifid_a, ifid_b;
    logic   ifid_valid_a, ifid_valid_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    fetch_stage #(
        .PC_INIT(32'h0000_0000)
    ) u_dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN_a),
        .imemaddr    (imemaddr_a),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_in     (halt_in),
        .ifid        (ifid_a),
        .ifid_valid  (ifid_valid_a)
    );

    fetch_stage #(
        .PC_INIT(32'hFFFF_FFFC)
    ) u_dut_wrap (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN_b),
        .imemaddr    (imemaddr_b),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_in     (halt_in),
        .ifid        (ifid_b),
        .ifid_valid  (ifid_valid_b)
    );

    // Memory returns a word tagged with the address it was read from.
    assign imemload = imemaddr_a ^ LOAD_KEY;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic hit_level);
        nRST        = 1'b0;
        ihit        = hit_level;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt_in     = 1'b0;
        #2;
        check_eq("rst_ren",   {31'd0, imemREN_a},    32'd0);
        check_eq("rst_valid", {31'd0, ifid_valid_a}, 32'd0);
        check_eq("rst_addr",  imemaddr_a,            32'h0000_0000);
        check_eq("rst_ifid",  ifid_a.pc,             32'h0000_0000);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic check_ifid(input string tag, input word_t exp_pc);
        check_eq({tag, "_valid"}, {31'd0, ifid_valid_a}, 32'd1);
        check_eq({tag, "_pc"},    ifid_a.pc,             exp_pc);
        check_eq({tag, "_pc4"},   ifid_a.pc4,            exp_pc + 32'd4);
        check_eq({tag, "_load"},  ifid_a.imemload,       exp_pc ^ LOAD_KEY);
    endtask

    initial begin
        // Sequential fetch with ihit always high, plus wrap instance
        do_reset(1'b1);
        check_eq("wrap_rst_addr", imemaddr_b, 32'hFFFF_FFFC);
        tick();
        check_eq("e1_ren",   {31'd0, imemREN_a},    32'd1);
        check_eq("e1_addr",  imemaddr_a,            32'h0000_0000);
        check_eq("e1_valid", {31'd0, ifid_valid_a}, 32'd0);
        tick();
        check_ifid("e2", 32'h0000_0000);
        check_eq("e2_addr", imemaddr_a, 32'h0000_0004);
        check_eq("wrap_ifid_pc4", ifid_b.pc4, 32'h0000_0000);
        check_eq("wrap_addr",     imemaddr_b, 32'h0000_0000);
        tick();
        check_ifid("e3", 32'h0000_0004);
        check_eq("e3_addr", imemaddr_a, 32'h0000_0008);

        // Stall two cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_ifid("stall_hold", 32'h0000_0004);
            check_eq("stall_addr", imemaddr_a, 32'h0000_0008);
        end
        stall = 1'b0;
        tick();
        check_ifid("stall_rel", 32'h0000_0008);
        check_eq("stall_rel_addr", imemaddr_a, 32'h0000_000C);

        // Flush overrides stall
        flush = 1'b1;
        stall = 1'b1;
        tick();
        check_eq("flush_valid", {31'd0, ifid_valid_a}, 32'd0);
        check_eq("flush_pc",    ifid_a.pc,             32'h0000_0000);
        check_eq("flush_load",  ifid_a.imemload,       32'h0000_0000);
        check_eq("flush_addr",  imemaddr_a,            32'h0000_000C);
        flush = 1'b0;
        stall = 1'b0;
        tick();
        check_ifid("post_flush", 32'h0000_000C);

        // Redirect while the request is outstanding
        do_reset(1'b0);
        tick();
        check_eq("d_ren", {31'd0, imemREN_a}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0041;
        tick();
        redirect = 1'b0;
        check_eq("d1_addr", imemaddr_a, 32'h0000_0000);
        tick();
        check_eq("d2_addr", imemaddr_a, 32'h0000_0000);
        tick();
        check_eq("d3_addr",  imemaddr_a,            32'h0000_0000);
        check_eq("d3_valid", {31'd0, ifid_valid_a}, 32'd0);
        ihit = 1'b1;
        tick();
        check_eq("d_hit_addr",  imemaddr_a,            32'h0000_0040);
        check_eq("d_hit_valid", {31'd0, ifid_valid_a}, 32'd0);
        tick();
        check_ifid("d_tgt", 32'h0000_0040);

        // Redirect with ihit in FETCH, under stall
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        stall       = 1'b1;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check_eq("r_addr", imemaddr_a, 32'h0000_0100);
        check_ifid("r_hold", 32'h0000_0040);
        tick();
        check_eq("r_bubble", {31'd0, ifid_valid_a}, 32'd1);
        check_ifid("r_tgt", 32'h0000_0100);

        // Halt beats a simultaneous redirect; only reset leaves HALTED
        halt_in     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        halt_in  = 1'b0;
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("halt_ren",   {31'd0, imemREN_a},    32'd0);
            check_eq("halt_valid", {31'd0, ifid_valid_a}, 32'd0);
            tick();
        end
        do_reset(1'b1);
        tick();
        check_eq("resume_ren",  {31'd0, imemREN_a}, 32'd1);
        check_eq("resume_addr", imemaddr_a,         32'h0000_0000);
        tick();
        check_ifid("resume", 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
